// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester SRAM arbiter: FSM state encoding,
// requester identifiers and default parameter widths.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Requester identifiers, also used as the round-robin "last winner" value.
  localparam logic ARB_IF = 1'b0;
  localparam logic ARB_DM = 1'b1;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one combinational-read SRAM between the instruction-fetch (IF) and
// data (DM) requesters. A request is granted combinationally in IDLE, the SRAM
// is accessed for exactly one cycle in ACCESS, and the winner sees an rvalid
// pulse (with registered read data) on the following cycle. Ties are broken
// round-robin; cycles in which any request waits are counted (saturating).
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   if_req/if_addr       fetch request, held until if_gnt
//   if_gnt               fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata   one-cycle completion pulse / registered fetch data
//   dm_req/dm_addr       data request, held until dm_gnt
//   dm_w_en/dm_wdata     byte write enables (all zero = read) / store data
//   dm_gnt               data request accepted this cycle (combinational)
//   dm_rvalid/dm_rdata   one-cycle completion pulse / registered load data
//   sram_*               SRAM address, byte write enables, write/read data
//   busy                 high while an access is in progress
//   conflict_cnt         saturating count of cycles with a waiting request
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,

  input  logic                  dm_req,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W/8-1:0]   dm_w_en,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     dm_rdata,

  output logic [DATA_W/8-1:0]   sram_w_en,
  output logic [ADDR_W-1:0]     sram_address,
  output logic [DATA_W-1:0]     sram_write_data,
  input  logic [DATA_W-1:0]     sram_read_data,

  output logic                  busy,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int BE_W = DATA_W / 8;

  state_t              state;
  state_t              state_next;
  logic                last_winner;

  // Request registers: snapshot of the granted request, replayed to the SRAM
  // during ACCESS.
  logic                req_id;
  logic [ADDR_W-1:0]   req_addr;
  logic [BE_W-1:0]     req_w_en;
  logic [DATA_W-1:0]   req_wdata;

  logic                any_gnt;
  logic                pending;
  logic                req_is_read;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_gnt) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (grants and SRAM strobes)
  // -------------------------------------------------------------------------
  // On a tie the requester that did not win last time is served; a lone
  // requester is always served.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    sram_w_en = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if_gnt = if_req && (!dm_req || (last_winner == ARB_DM));
        dm_gnt = dm_req && (!if_req || (last_winner == ARB_IF));
      end
      ACCESS: begin
        sram_w_en = req_w_en;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign any_gnt = if_gnt | dm_gnt;

  // The request registers only change on the edge that enters ACCESS, so
  // driving the SRAM bus from them directly keeps address and write data
  // stable outside ACCESS.
  assign sram_address    = req_addr;
  assign sram_write_data = req_wdata;

  // -------------------------------------------------------------------------
  // Request capture and round-robin history
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_winner <= ARB_DM;
      req_id      <= ARB_IF;
      req_addr    <= '0;
      req_w_en    <= '0;
      req_wdata   <= '0;
    end else if (any_gnt) begin
      last_winner <= dm_gnt ? ARB_DM : ARB_IF;
      req_id      <= dm_gnt ? ARB_DM : ARB_IF;
      req_addr    <= dm_gnt ? dm_addr : if_addr;
      // Fetches never write.
      req_w_en    <= dm_gnt ? dm_w_en : '0;
      if (dm_gnt) begin
        req_wdata <= dm_wdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Completion: rvalid pulses and registered read data
  // -------------------------------------------------------------------------
  assign req_is_read = (req_w_en == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= (state == ACCESS) && (req_id == ARB_IF);
      dm_rvalid <= (state == ACCESS) && (req_id == ARB_DM);
      if ((state == ACCESS) && req_is_read) begin
        if (req_id == ARB_IF) begin
          if_rdata <= sram_read_data;
        end else begin
          dm_rdata <= sram_read_data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Contention counter: one increment per cycle with any ungranted request
  // -------------------------------------------------------------------------
  assign pending = (if_req && !if_gnt) || (dm_req && !dm_gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (pending && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule : mem_arbiter
